// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide ripple of full adders followed by its sum/carry register.
module adder_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_q,
    output logic             cout_q
);

    logic [CHUNK-1:0] sum_d;
    logic             cout_d;
    logic [CHUNK:0]   cy;

    always_comb begin
        cy    = '0;
        sum_d = '0;
        cy[0] = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_d[i] = a_i[i] ^ b_i[i] ^ cy[i];
            cy[i+1]  = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
        end
        cout_d = cy[CHUNK];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor, carry chain split over STAGES registered chunks.
// Optional overflow output enabled by defining PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int L     = STAGES - 1;

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] vld_d, vld_q;
    mode_e             mode_d [STAGES];
    mode_e             mode_q [STAGES];

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign out_valid = vld_q[L];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // SUB is a + ~b + ~borrow_in; inversion happens once, at entry.
    assign b_eff   = (mode_e'(mode) == SUB) ? ~b : b;
    assign cin_eff = (mode_e'(mode) == SUB) ? ~carryin : carryin;

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        if (adv) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                vld_d[k]  = vld_q[k-1];
                mode_d[k] = mode_q[k-1];
            end
            vld_d[0]  = in_valid;
            mode_d[0] = mode_e'(mode);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                mode_q[k] <= ADD;
            end
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SKW = WIDTH - (k + 1) * CHUNK;

        logic [CHUNK-1:0] a_in, b_in, s_q;
        logic             c_in, c_q;

        if (k == 0) begin : g_src
            assign a_in = a[CHUNK-1:0];
            assign b_in = b_eff[CHUNK-1:0];
            assign c_in = cin_eff;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_skw.a_q[CHUNK-1:0];
            assign b_in = g_stg[k-1].g_skw.b_q[CHUNK-1:0];
            assign c_in = g_stg[k-1].c_q;
        end

        adder_stage #(.CHUNK(CHUNK)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .en     (adv),
            .a_i    (a_in),
            .b_i    (b_in),
            .c_i    (c_in),
            .sum_q  (s_q),
            .cout_q (c_q)
        );

        // Skew: operand chunks not yet added ride along with their carry.
        if (SKW > 0) begin : g_skw
            logic [SKW-1:0] a_d, b_d, a_q, b_q;

            if (k == 0) begin : g_in
                always_comb begin
                    a_d = a[WIDTH-1:CHUNK];
                    b_d = b_eff[WIDTH-1:CHUNK];
                end
            end else begin : g_in
                always_comb begin
                    a_d = g_stg[k-1].g_skw.a_q[SKW+CHUNK-1:CHUNK];
                    b_d = g_stg[k-1].g_skw.b_q[SKW+CHUNK-1:CHUNK];
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // Deskew: finished low sum chunks wait for the upper chunks.
        if (k > 0) begin : g_dsk
            logic [k*CHUNK-1:0] lo_d, lo_q;

            if (k == 1) begin : g_in
                always_comb lo_d = g_stg[0].s_q;
            end else begin : g_in
                always_comb lo_d = {g_stg[k-1].s_q, g_stg[k-1].g_dsk.lo_q};
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    lo_q <= '0;
                end else if (adv) begin
                    lo_q <= lo_d;
                end
            end
        end
    end

    if (STAGES == 1) begin : g_out
        assign sum = g_stg[0].s_q;
    end else begin : g_out
        assign sum = {g_stg[L].s_q, g_stg[L].g_dsk.lo_q};
    end

    assign carryout = g_stg[L].c_q ^ (mode_q[L] == SUB);

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic msb_a_d, msb_b_d, msb_a_q, msb_b_q;

    always_comb begin
        msb_a_d = g_stg[L].a_in[CHUNK-1];
        msb_b_d = g_stg[L].b_in[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
        end else if (adv) begin
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
        end
    end

    // Carry into the MSB recovered as a ^ b ^ s at that bit.
    assign overflow = msb_a_q ^ msb_b_q ^ sum[WIDTH-1] ^ g_stg[L].c_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: queue-based reference model plus directed literal vectors.
module tb_pipelined_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, carryin, mode, out_valid, out_ready, carryout;
    logic [W-1:0] a, b, sum;
    logic         r1_in_valid, r1_in_ready, r1_a, r1_b, r1_cin, r1_mode;
    logic         r1_out_valid, r1_out_ready, r1_sum, r1_cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic         overflow, r1_overflow;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       ovf;
        logic       cout;
        logic [7:0] sum;
    } res_t;

    res_t       sb[$];
    logic [1:0] fa_tt [8];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carryin   (carryin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    pipelined_adder #(.WIDTH(1), .STAGES(1)) dut_fa (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r1_in_valid),
        .in_ready  (r1_in_ready),
        .a         (r1_a),
        .b         (r1_b),
        .carryin   (r1_cin),
        .mode      (r1_mode),
        .out_valid (r1_out_valid),
        .out_ready (r1_out_ready),
        .sum       (r1_sum),
        .carryout  (r1_cout)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        ,
        .overflow  (r1_overflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned result, borrow/carry, signed range test.
    function automatic res_t model(input int w, input logic [7:0] x, input logic [7:0] y,
                                   input logic c, input logic m);
        int   mx, ux, uy, sx, sy, ru, rs;
        res_t r;
        mx = 1 << w;
        ux = int'(x) & (mx - 1);
        uy = int'(y) & (mx - 1);
        sx = (ux >= mx / 2) ? ux - mx : ux;
        sy = (uy >= mx / 2) ? uy - mx : uy;
        if (m) begin
            ru     = ux - uy - int'(c);
            rs     = sx - sy - int'(c);
            r.cout = (ru < 0);
        end else begin
            ru     = ux + uy + int'(c);
            rs     = sx + sy + int'(c);
            r.cout = (ru >= mx);
        end
        r.sum = 8'(ru & (mx - 1));
        r.ovf = (rs < -(mx / 2)) || (rs >= mx / 2);
        return r;
    endfunction

    // Scoreboard: inspects the cycle just before each rising edge.
    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            sb.delete();
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check("sb_sum", 32'(sum), 32'(e.sum));
                    check("sb_carryout", 32'(carryout), 32'(e.cout));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                    check("sb_overflow", 32'(overflow), 32'(e.ovf));
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(model(W, a, b, carryin, mode));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        carryin  = c;
        mode     = m;
    endtask

    task automatic directed(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m,
                            input logic [7:0] es, input logic ec, input logic eo, input string nm);
        step();
        drive(x, y, c, m);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_latency"}, 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_sum"}, 32'(sum), 32'(es));
        check({nm, "_carryout"}, 32'(carryout), 32'(ec));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        check({nm, "_overflow"}, 32'(overflow), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X overflow literal");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         idx;
        bit         saw_low;
        logic [7:0] got[$];
        res_t       e;

        fa_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        reset        = 1'b1;
        in_valid     = 1'b1;
        a            = 8'hFF;
        b            = 8'h01;
        carryin      = 1'b0;
        mode         = 1'b0;
        out_ready    = 1'b1;
        r1_in_valid  = 1'b0;
        r1_a         = 1'b0;
        r1_b         = 1'b0;
        r1_cin       = 1'b0;
        r1_mode      = 1'b0;
        r1_out_ready = 1'b1;

        repeat (3) step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_carryout", 32'(carryout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        check("rst_overflow", 32'(overflow), 32'd0);
`endif

        directed(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        directed(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        directed(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, "sub_05_07");
        directed(8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "sub_07_05_b1");
        directed(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        directed(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_00_00_b1");

        // Back-to-back mixed ADD/SUB stream at full rate.
        step();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] x, y;
            x = 8'(37 * i + 200);
            y = 8'(91 * i + 5);
            drive(x, y, i[0], i[1]);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Backpressure: out_ready low during cycles 2..6.
        idx     = 0;
        saw_low = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            if (idx < 4) drive(8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            if (c >= 3 && c <= 6) begin
                check("bp_stall_valid", 32'(out_valid), 32'd1);
                check("bp_stall_sum", 32'(sum), 32'h02);
            end
            if (out_valid && out_ready) got.push_back(sum);
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_in_ready_dropped", 32'(saw_low), 32'd1);
        check("bp_result_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_order", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(2 * (i + 1)));
        end

        // Reset with two operations in flight.
        out_ready = 1'b0;
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        step();
        drive(8'h33, 8'h44, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_no_result", 32'(out_valid), 32'd0);
            step();
        end
        directed(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "post_reset");

        // One-bit, one-stage instance against the full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step();
            check("fa_in_ready", 32'(r1_in_ready), 32'd1);
            r1_in_valid = 1'b1;
            r1_a        = v[2];
            r1_b        = v[1];
            r1_cin      = v[0];
            r1_mode     = 1'b0;
            step();
            r1_in_valid = 1'b0;
            @(negedge clk);
            e = model(1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0);
            check("fa_valid", 32'(r1_out_valid), 32'd1);
            check("fa_truth_table", 32'({r1_cout, r1_sum}), 32'(fa_tt[i]));
            check("fa_model", 32'({r1_cout, r1_sum}), 32'({e.cout, e.sum[0]}));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            check("fa_overflow", 32'(r1_overflow), 32'(e.ovf));
`endif
        end

        repeat (4) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
